// File: rtl/dmem_access_sequencer_pkg.sv
// Shared definitions for the data-memory access sequencer: width codes,
// controller states and small helpers for alignment and store lane packing.
package dmem_access_sequencer_pkg;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  localparam logic [2:0] STORE_SB = 3'b000;
  localparam logic [2:0] STORE_SH = 3'b001;
  localparam logic [2:0] STORE_SW = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_RESP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic is_load_code(input logic [2:0] f3);
    return (f3 == LOAD_LB) || (f3 == LOAD_LH) || (f3 == LOAD_LW) ||
           (f3 == LOAD_LBU) || (f3 == LOAD_LHU);
  endfunction

  function automatic logic is_store_code(input logic [2:0] f3);
    return (f3 == STORE_SB) || (f3 == STORE_SH) || (f3 == STORE_SW);
  endfunction

  // size: 00 byte, 01 half, 10 word (low two bits of funct3)
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~addr_lo[0];
      default: ok = (addr_lo == 2'b00);
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] mask;
    case (size)
      2'b00:   mask = 4'b0001 << addr_lo;
      2'b01:   mask = 4'b0011 << addr_lo;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] lanes;
    case (size)
      2'b00:   lanes = {4{data[7:0]}};
      2'b01:   lanes = {2{data[15:0]}};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/dmem_access_sequencer_load_lane_align.sv
// Load lane extraction: shifts the addressed lane of the returned word down
// to bit 0 and sign- or zero-extends it according to the load width code.
module load_lane_align
  import dmem_access_sequencer_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_byte_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_result
);

  logic [31:0] w_shifted;

  // Select the lane and apply the extension rule for this load width
  always_comb begin
    w_shifted = i_rdata >> {i_byte_offset, 3'b000};
    o_result  = w_shifted;
    case (i_funct3)
      LOAD_LB:  o_result = {{24{w_shifted[7]}}, w_shifted[7:0]};
      LOAD_LBU: o_result = {24'd0, w_shifted[7:0]};
      LOAD_LH:  o_result = {{16{w_shifted[15]}}, w_shifted[15:0]};
      LOAD_LHU: o_result = {16'd0, w_shifted[15:0]};
      default:  o_result = w_shifted;
    endcase
  end

endmodule

// File: rtl/dmem_access_sequencer.sv
// Multi-cycle load/store sequencer between the MEM stage and a req/ack data
// bus with variable read latency. Handles alignment traps, byte lanes,
// pipeline stall, per-access timeout and flush abort.
module dmem_access_sequencer
  import dmem_access_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] register_file_read_data,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] register_file_write_data,
  output logic        load_done,
  output logic        misaligned_load,
  output logic        misaligned_store,
  output logic        access_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  state_t r_state;
  state_t w_state_next;

  logic [31:0]   r_addr;
  logic [2:0]    r_funct3;
  logic          r_is_load;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wmask;
  logic [CW-1:0] r_count;
  logic [31:0]   r_result;
  logic          r_misaligned_load;
  logic          r_misaligned_store;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_req_valid;
  logic        w_aligned;
  logic        w_start;
  logic        w_timeout;
  logic        w_enter_req;
  logic        w_capture;
  logic [31:0] w_load_result;

  // Read wins when both strobes are up; undefined width codes are no request
  assign w_is_load   = memory_read && is_load_code(funct3);
  assign w_is_store  = !memory_read && memory_write && is_store_code(funct3);
  assign w_req_valid = w_is_load || w_is_store;
  assign w_aligned   = is_aligned(funct3[1:0], address[1:0]);
  assign w_start     = w_req_valid && w_aligned && !flush;
  assign w_timeout   = (r_count == LAST_COUNT);

  assign mem_addr                 = {r_addr[31:2], 2'b00};
  assign mem_wdata                = r_wdata;
  assign register_file_write_data = r_result;
  assign misaligned_load          = r_misaligned_load;
  assign misaligned_store         = r_misaligned_store;

  load_lane_align u_load_lane_align (
    .i_rdata       (mem_rdata),
    .i_byte_offset (r_addr[1:0]),
    .i_funct3      (r_funct3),
    .o_result      (w_load_result)
  );

  // Controller state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, stall and bus strobes for the access in flight
  always_comb begin
    w_state_next = r_state;
    stall        = 1'b0;
    load_done    = 1'b0;
    access_fault = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_wmask    = 4'b0000;
    w_enter_req  = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          stall        = 1'b1;
          w_enter_req  = 1'b1;
          w_state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = !r_is_load;
        mem_wmask = r_is_load ? 4'b0000 : r_wmask;
        if (mem_ack) begin
          if (r_is_load) begin
            w_state_next = flush ? ST_DRAIN : ST_RESP;
          end else begin
            w_state_next = flush ? ST_IDLE : ST_DONE;
          end
        end else if (flush) begin
          w_state_next = ST_IDLE;
        end else if (w_timeout) begin
          stall        = 1'b0;
          access_fault = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_RESP: begin
        stall = 1'b1;
        if (flush) begin
          w_state_next = mem_rvalid ? ST_IDLE : ST_DRAIN;
        end else if (mem_rvalid) begin
          w_capture    = 1'b1;
          w_state_next = ST_DONE;
        end else if (w_timeout) begin
          stall        = 1'b0;
          access_fault = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        stall = w_req_valid;
        if (mem_rvalid || w_timeout) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_DONE: begin
        load_done    = r_is_load;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Latched request, timeout counter, load result and misalignment pulses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr             <= '0;
      r_funct3           <= '0;
      r_is_load          <= 1'b0;
      r_wdata            <= '0;
      r_wmask            <= '0;
      r_count            <= '0;
      r_result           <= '0;
      r_misaligned_load  <= 1'b0;
      r_misaligned_store <= 1'b0;
    end else begin
      r_misaligned_load  <= (r_state == ST_IDLE) && w_is_load && !w_aligned && !flush;
      r_misaligned_store <= (r_state == ST_IDLE) && w_is_store && !w_aligned && !flush;
      if (w_enter_req) begin
        r_addr    <= address;
        r_funct3  <= funct3;
        r_is_load <= w_is_load;
        r_wdata   <= store_data(funct3[1:0], register_file_read_data);
        r_wmask   <= store_mask(funct3[1:0], address[1:0]);
        r_count   <= '0;
      end else if ((r_state == ST_REQ) || (r_state == ST_RESP) || (r_state == ST_DRAIN)) begin
        r_count <= r_count + CW'(1);
      end
      if (w_capture) begin
        r_result <= w_load_result;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_sequencer.sv
// Self-checking bench for the data-memory access sequencer: directed cases
// plus randomized loads/stores checked against a timeline/arithmetic model.
module tb_dmem_access_sequencer;

  localparam int TIMEOUT = 8;

  logic        clk;
  logic        reset_n;
  logic        memory_read;
  logic        memory_write;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] register_file_read_data;
  logic        flush;
  logic        stall;
  logic [31:0] register_file_write_data;
  logic        load_done;
  logic        misaligned_load;
  logic        misaligned_store;
  logic        access_fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checkCount = 0;
  int passCount  = 0;
  logic [31:0] lastResult = 32'd0;

  dmem_access_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .memory_read              (memory_read),
    .memory_write             (memory_write),
    .funct3                   (funct3),
    .address                  (address),
    .register_file_read_data  (register_file_read_data),
    .flush                    (flush),
    .stall                    (stall),
    .register_file_write_data (register_file_write_data),
    .load_done                (load_done),
    .misaligned_load          (misaligned_load),
    .misaligned_store         (misaligned_store),
    .access_fault             (access_fault),
    .mem_req                  (mem_req),
    .mem_we                   (mem_we),
    .mem_addr                 (mem_addr),
    .mem_wdata                (mem_wdata),
    .mem_wmask                (mem_wmask),
    .mem_ack                  (mem_ack),
    .mem_rvalid               (mem_rvalid),
    .mem_rdata                (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit isLoad, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2);
    memory_read             = isLoad;
    memory_write            = !isLoad;
    funct3                  = f3;
    address                 = addr;
    register_file_read_data = rs2;
  endtask

  task automatic clearRequest();
    memory_read             = 1'b0;
    memory_write            = 1'b0;
    funct3                  = 3'b000;
    address                 = 32'd0;
    register_file_read_data = 32'd0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Expected load value from plain integer arithmetic on the returned word
  function automatic logic [31:0] refLoad(input logic [2:0] f3, input int off, input logic [31:0] rdata);
    longint word;
    longint v;
    word = longint'(rdata);
    case (f3)
      3'b000: begin v = (word >> (8 * off)) % 256;   if (v >= 128)   v = v - 256;   end
      3'b100: v = (word >> (8 * off)) % 256;
      3'b001: begin v = (word >> (8 * off)) % 65536; if (v >= 32768) v = v - 65536; end
      3'b101: v = (word >> (8 * off)) % 65536;
      default: v = word;
    endcase
    return v[31:0];
  endfunction

  // One access, starting just after a rising edge with the DUT idle.
  // ackWait: REQ cycles before the ack cycle; rvWait: RESP cycles before rvalid.
  task automatic runAccess(input bit isLoad, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rs2, input logic [31:0] rdata,
                           input int ackWait, input int rvWait);
    int nBytes;
    int off;
    int doneCyc;
    bit aligned;
    logic [31:0] expData;
    logic [3:0]  expMask;
    nBytes  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off     = int'(addr[1:0]);
    aligned = (off % nBytes) == 0;
    expData = (nBytes == 1) ? 32'(rs2[7:0]) * 32'h01010101 :
              (nBytes == 2) ? 32'(rs2[15:0]) * 32'h00010001 : rs2;
    expMask = 4'(((1 << nBytes) - 1) << off);
    applyStimulus(isLoad, f3, addr, rs2);
    if (!aligned) begin
      @(negedge clk);
      checkOutput("misalignStall", 32'(stall), 32'd0);
      checkOutput("misalignReq", 32'(mem_req), 32'd0);
      nextCycle();
      clearRequest();
      @(negedge clk);
      checkOutput("misalignedLoad", 32'(misaligned_load), 32'(isLoad));
      checkOutput("misalignedStore", 32'(misaligned_store), 32'(!isLoad));
      checkOutput("misalignReqAfter", 32'(mem_req), 32'd0);
      nextCycle();
      return;
    end
    doneCyc = isLoad ? 3 + ackWait + rvWait : 2 + ackWait;
    for (int c = 0; c <= doneCyc; c++) begin
      if (c > 0) nextCycle();
      mem_ack    = (c == 1 + ackWait);
      mem_rvalid = isLoad && (c == 2 + ackWait + rvWait);
      mem_rdata  = mem_rvalid ? rdata : $urandom();
      @(negedge clk);
      checkOutput("stall", 32'(stall), 32'(c < doneCyc));
      checkOutput("memReq", 32'(mem_req), 32'((c >= 1) && (c <= 1 + ackWait)));
      checkOutput("loadDone", 32'(load_done), 32'(isLoad && (c == doneCyc)));
      if (c == 1) begin
        checkOutput("memAddr", mem_addr, addr & 32'hFFFF_FFFC);
        checkOutput("memWe", 32'(mem_we), 32'(!isLoad));
        checkOutput("memWmask", 32'(mem_wmask), isLoad ? 32'd0 : 32'(expMask));
        if (!isLoad) checkOutput("memWdata", mem_wdata, expData);
      end
    end
    if (isLoad) lastResult = refLoad(f3, off, rdata);
    checkOutput("loadResult", register_file_write_data, lastResult);
    nextCycle();
    clearRequest();
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    flush      = 1'b0;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    clearRequest();
    repeat (2) nextCycle();
    @(negedge clk);
    checkOutput("resetStall", 32'(stall), 32'd0);
    checkOutput("resetReq", 32'(mem_req), 32'd0);
    checkOutput("resetResult", register_file_write_data, 32'd0);
    checkOutput("resetAddr", mem_addr, 32'd0);
    checkOutput("resetMask", 32'(mem_wmask), 32'd0);
    checkOutput("resetPulses", 32'({load_done, access_fault, misaligned_load, misaligned_store}), 32'd0);
    nextCycle();
    reset_n = 1'b1;

    $display("[TB] directed loads and stores");
    runAccess(1, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0, 1);
    runAccess(1, 3'b000, 32'h103, 32'd0, 32'h80112233, 0, 0);
    runAccess(1, 3'b100, 32'h103, 32'd0, 32'h80112233, 1, 2);
    runAccess(1, 3'b101, 32'h102, 32'd0, 32'h80112233, 2, 0);
    runAccess(0, 3'b001, 32'h206, 32'h1234ABCD, 32'd0, 0, 0);
    runAccess(1, 3'b010, 32'h101, 32'd0, 32'd0, 0, 0);
    runAccess(0, 3'b001, 32'h203, 32'h55AA55AA, 32'd0, 0, 0);

    $display("[TB] undefined width code");
    applyStimulus(1, 3'b011, 32'h100, 32'd0);
    @(negedge clk);
    checkOutput("undefStall", 32'(stall), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("undefReq", 32'(mem_req), 32'd0);
    checkOutput("undefPulse", 32'(misaligned_load), 32'd0);
    nextCycle();
    clearRequest();

    $display("[TB] timeout");
    applyStimulus(1, 3'b010, 32'h300, 32'd0);
    for (int c = 0; c <= TIMEOUT; c++) begin
      if (c > 0) nextCycle();
      @(negedge clk);
      checkOutput("toFault", 32'(access_fault), 32'(c == TIMEOUT));
      checkOutput("toStall", 32'(stall), 32'(c < TIMEOUT));
    end
    nextCycle();
    clearRequest();
    @(negedge clk);
    checkOutput("toReqDropped", 32'(mem_req), 32'd0);
    checkOutput("toResult", register_file_write_data, lastResult);
    nextCycle();

    $display("[TB] flush during response");
    applyStimulus(1, 3'b010, 32'h104, 32'd0);
    nextCycle();
    mem_ack = 1'b1;
    nextCycle();
    mem_ack = 1'b0;
    flush   = 1'b1;
    nextCycle();
    flush = 1'b0;
    applyStimulus(0, 3'b010, 32'h208, 32'hCAFEF00D);
    @(negedge clk);
    checkOutput("drainStall", 32'(stall), 32'd1);
    checkOutput("drainReq", 32'(mem_req), 32'd0);
    checkOutput("drainDone", 32'(load_done), 32'd0);
    nextCycle();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_5555;
    @(negedge clk);
    checkOutput("drainDone2", 32'(load_done), 32'd0);
    nextCycle();
    mem_rvalid = 1'b0;
    runAccess(0, 3'b010, 32'h208, 32'hCAFEF00D, 32'd0, 1, 0);

    $display("[TB] reset mid-access");
    applyStimulus(1, 3'b010, 32'h400, 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("midReqUp", 32'(mem_req), 32'd1);
    nextCycle();
    reset_n = 1'b0;
    nextCycle();
    reset_n = 1'b1;
    clearRequest();
    lastResult = 32'd0;
    @(negedge clk);
    checkOutput("midReqDrop", 32'(mem_req), 32'd0);
    checkOutput("midStall", 32'(stall), 32'd0);
    nextCycle();

    $display("[TB] randomized accesses");
    for (int i = 0; i < 40; i++) begin
      bit          isLoad;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          pick;
      isLoad = ($urandom_range(0, 1) == 1);
      if (isLoad) begin
        pick = $urandom_range(0, 4);
        f3   = (pick == 0) ? 3'b000 : (pick == 1) ? 3'b001 : (pick == 2) ? 3'b010 :
               (pick == 3) ? 3'b100 : 3'b101;
      end else begin
        pick = $urandom_range(0, 2);
        f3   = 3'(pick);
      end
      addr = $urandom();
      if ($urandom_range(0, 3) != 0) begin
        addr[1:0] = (f3[1:0] == 2'b10) ? 2'b00 : (f3[1:0] == 2'b01) ? {addr[1], 1'b0} : addr[1:0];
      end
      runAccess(isLoad, f3, addr, $urandom(), $urandom(),
                $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
